// File: rtl/prog_mem_ldr.sv
// Loadable program memory with a registered multi-byte fetch port.
// A byte-stream loader writes the image, zero-fills the tail and sums it.
module prog_mem_ldr #(
  parameter int ADDRWIDTH   = 8,
  parameter int FETCH_BYTES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     CS,
  input  logic [ADDRWIDTH-1:0]     addr,
  output logic [8*FETCH_BYTES-1:0] dout,
  output logic                     fetch_ok,
  input  logic                     ld_start,
  input  logic [ADDRWIDTH:0]       ld_len,
  input  logic                     ld_valid,
  input  logic [7:0]               ld_data,
  output logic                     ld_ready,
  output logic                     busy,
  output logic                     ld_done,
  output logic [7:0]               ld_sum
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] FULL =
    {1'b1, {ADDRWIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL
  } state_t;

  state_t               state, state_n;
  logic [ADDRWIDTH-1:0] wptr, wptr_n;
  logic [ADDRWIDTH:0]   len, len_n;
  logic [7:0]           sum, sum_n;
  logic                 done, done_n;
  logic                 we;
  logic [7:0]           wdata;
  logic                 fetch;
  logic [8*FETCH_BYTES-1:0] rdata;

  logic [7:0] mem [DEPTH];

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    len_n   = len;
    sum_n   = sum;
    done_n  = 1'b0;
    we      = 1'b0;
    wdata   = 8'h00;
    case (state)
      IDLE: begin
        if (ld_start) begin
          len_n   = ld_len;
          wptr_n  = '0;
          sum_n   = '0;
          state_n = (ld_len != '0) ? LOAD : FILL;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          we     = 1'b1;
          wdata  = ld_data;
          sum_n  = sum + ld_data;
          wptr_n = wptr + ADDRWIDTH'(1);
          if ({1'b0, wptr} == len - (ADDRWIDTH+1)'(1)) begin
            if (len == FULL) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = FILL;
            end
          end
        end
      end
      FILL: begin
        we     = 1'b1;
        wptr_n = wptr + ADDRWIDTH'(1);
        if (&wptr) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A start request claims the cycle, so a fetch seen with it is dropped.
  assign fetch = (state == IDLE) && !CS && !ld_start;

  always_comb begin
    rdata = '0;
    for (int k = 0; k < FETCH_BYTES; k++) begin
      rdata[8*k +: 8] = mem[addr + ADDRWIDTH'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wptr     <= '0;
      len      <= '0;
      sum      <= '0;
      done     <= 1'b0;
      dout     <= '0;
      fetch_ok <= 1'b0;
    end else begin
      state    <= state_n;
      wptr     <= wptr_n;
      len      <= len_n;
      sum      <= sum_n;
      done     <= done_n;
      dout     <= fetch ? rdata : '0;
      fetch_ok <= fetch;
    end
  end

  // Array is never cleared; reset only blocks the write on its edge.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[wptr] <= wdata;
    end
  end

  assign busy     = (state != IDLE);
  assign ld_ready = (state == LOAD);
  assign ld_done  = done;
  assign ld_sum   = sum;

endmodule
